// File: rtl/osc_stimulus_gen_pkg.sv
// Shared types and elaboration-time helpers for the on-chip square-wave stimulus source.
// Also provides the millisecond clock count reused by the measurement timer.
package osc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } osc_state_e;

  typedef logic [7:0] freq_khz_t;

  localparam int ACC_W_DEF       = 24;
  localparam int CLK_FREQ_HZ_DEF = 10_000_000;
  localparam int CLKS_PER_MS     = CLK_FREQ_HZ_DEF / 32'sd1000;

  function automatic int clks_per_ms(input int clk_hz);
    return clk_hz / 32'sd1000;
  endfunction

  // Phase increment per kHz, rounded to nearest: round(2^acc_w * 1000 / clk_hz).
  function automatic int nco_k(input int clk_hz, input int acc_w);
    longint num;
    num = (64'sd1 <<< acc_w) * 64'sd1000 + longint'(clk_hz / 32'sd2);
    return int'(num / longint'(clk_hz));
  endfunction

endpackage

// File: rtl/osc_stimulus_gen_if.sv
// Control/status bundle between a self-test sequencer (master) and the stimulus source (slave).
interface osc_stimulus_gen_if;
  import osc_gen_pkg::*;

  freq_khz_t cfg_start;
  freq_khz_t cfg_stop;
  logic      cfg_sweep;
  logic      go;
  logic      halt;
  logic      osc_out;
  freq_khz_t cur_freq;
  logic      busy;
  logic      step_tick;
  logic      sweep_done;

  modport master (
    output cfg_start, cfg_stop, cfg_sweep, go, halt,
    input  osc_out, cur_freq, busy, step_tick, sweep_done
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_sweep, go, halt,
    output osc_out, cur_freq, busy, step_tick, sweep_done
  );
endinterface

// File: rtl/osc_stimulus_gen_ms_tick_gen.sv
// Free-running 1 ms tick generator: counts CLKS_PER_MS_P-1 down to 0 and ticks on 0.
// clear reloads the count so the first tick lands exactly one millisecond later.
module ms_tick_gen
  import osc_gen_pkg::*;
#(
  parameter int CLKS_PER_MS_P = CLKS_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_MS_P > 1) ? $clog2(CLKS_PER_MS_P) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_MS_P - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter with reload on zero; held while disabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= CNT_RELOAD;
    end else if (en) begin
      if (cnt_r == CNT_ZERO) begin
        cnt_r <= CNT_RELOAD;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && !clear && (cnt_r == CNT_ZERO);

endmodule

// File: rtl/osc_stimulus_gen.sv
// NCO square-wave stimulus source: fixed frequency or stepped sweep in 1 kHz steps,
// driving the frequency measurement input directly for loopback self-test.
module osc_stimulus_gen
  import osc_gen_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int DWELL_MS    = 2
) (
  input logic               clk,
  input logic               rst,
  osc_stimulus_gen_if.slave bus
);

  localparam int               MS_CLKS    = clks_per_ms(CLK_FREQ_HZ);
  localparam logic [ACC_W-1:0] NCO_K      = ACC_W'(nco_k(CLK_FREQ_HZ, ACC_W));
  localparam logic [ACC_W-1:0] ACC_ZERO   = {ACC_W{1'b0}};
  localparam int               DWELL_W    = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(32'd1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MS - 32'sd1);

  osc_state_e         state_r, state_n;
  freq_khz_t          stop_r, stop_n;
  logic               up_r, up_n;
  freq_khz_t          cur_freq_r, cur_freq_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic [ACC_W-1:0]   inc_r;
  logic [ACC_W-1:0]   acc_r, acc_n;
  logic               osc_out_r;
  logic               busy_r;
  logic               step_tick_r, step_tick_n;
  logic               sweep_done_r, sweep_done_n;
  logic               ms_tick_s;
  logic               dwell_end_s;
  logic               tick_en_s;

  // The ms timer only runs while sweeping and restarts on every entry into SWEEP.
  assign tick_en_s = (state_r == ST_SWEEP);

  ms_tick_gen #(
    .CLKS_PER_MS_P(MS_CLKS)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(!tick_en_s),
    .en   (tick_en_s),
    .tick (ms_tick_s)
  );

  // Next-state, dwell, frequency stepping and phase accumulation.
  always_comb begin
    state_n      = state_r;
    stop_n       = stop_r;
    up_n         = up_r;
    cur_freq_n   = cur_freq_r;
    acc_n        = acc_r;
    step_tick_n  = 1'b0;
    sweep_done_n = 1'b0;
    dwell_end_s  = 1'b0;

    if (ms_tick_s && (dwell_r == DWELL_LAST)) begin
      dwell_end_s = 1'b1;
      dwell_n     = DWELL_ZERO;
    end else if (ms_tick_s) begin
      dwell_n = dwell_r + DWELL_ONE;
    end else begin
      dwell_n = dwell_r;
    end

    case (state_r)
      ST_IDLE: begin
        acc_n = ACC_ZERO;
        if (bus.halt) begin
          state_n = ST_IDLE;
        end else if (bus.go) begin
          state_n    = bus.cfg_sweep ? ST_SWEEP : ST_RUN;
          stop_n     = bus.cfg_stop;
          up_n       = (bus.cfg_start < bus.cfg_stop);
          cur_freq_n = bus.cfg_start;
          dwell_n    = DWELL_ZERO;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_n = ST_IDLE;
          acc_n   = ACC_ZERO;
        end else begin
          acc_n = acc_r + inc_r;
        end
      end
      ST_SWEEP: begin
        if (bus.halt) begin
          state_n = ST_IDLE;
          acc_n   = ACC_ZERO;
        end else if (dwell_end_s && (cur_freq_r == stop_r)) begin
          state_n      = ST_DONE;
          sweep_done_n = 1'b1;
          acc_n        = ACC_ZERO;
        end else if (dwell_end_s) begin
          // Phase stays continuous across the step; only the increment changes.
          cur_freq_n  = up_r ? (cur_freq_r + 8'd1) : (cur_freq_r - 8'd1);
          step_tick_n = 1'b1;
          acc_n       = acc_r + inc_r;
        end else begin
          acc_n = acc_r + inc_r;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        acc_n   = ACC_ZERO;
      end
      default: begin
        state_n = ST_IDLE;
        acc_n   = ACC_ZERO;
      end
    endcase
  end

  // State, configuration, NCO and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      stop_r       <= 8'd0;
      up_r         <= 1'b0;
      cur_freq_r   <= 8'd0;
      dwell_r      <= DWELL_ZERO;
      inc_r        <= ACC_ZERO;
      acc_r        <= ACC_ZERO;
      osc_out_r    <= 1'b0;
      busy_r       <= 1'b0;
      step_tick_r  <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      stop_r       <= stop_n;
      up_r         <= up_n;
      cur_freq_r   <= cur_freq_n;
      dwell_r      <= dwell_n;
      inc_r        <= ACC_W'(cur_freq_r) * NCO_K;
      acc_r        <= acc_n;
      osc_out_r    <= acc_n[ACC_W-1];
      busy_r       <= (state_n == ST_RUN) || (state_n == ST_SWEEP);
      step_tick_r  <= step_tick_n;
      sweep_done_r <= sweep_done_n;
    end
  end

  assign bus.osc_out    = osc_out_r;
  assign bus.cur_freq   = cur_freq_r;
  assign bus.busy       = busy_r;
  assign bus.step_tick  = step_tick_r;
  assign bus.sweep_done = sweep_done_r;

endmodule

// File: tb/tb_osc_stimulus_gen.sv
// Scoreboard bench for osc_stimulus_gen: expected sweep events are queued at go time
// and a monitor pops/compares them whenever step_tick or sweep_done pulses.
module tb_osc_stimulus_gen;
  import osc_gen_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int N      = CLK_HZ / 1000;
  localparam int DW     = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    bit is_done;
    int freq;
    int when;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;

  osc_stimulus_gen_if bus ();

  osc_stimulus_gen #(
    .CLK_FREQ_HZ(CLK_HZ),
    .ACC_W      (24),
    .DWELL_MS   (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.step_tick || bus.sweep_done)) begin
      if (exp_q.size() == 0) begin
        check("event_expected", bus.step_tick + bus.sweep_done, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("ev_kind", bus.sweep_done, mon_ev.is_done);
        check("ev_freq", bus.cur_freq, mon_ev.freq);
        check_rng("ev_time", cyc, mon_ev.when - 2, mon_ev.when + 2);
      end
    end
  end

  task automatic start(input int s, input int t, input bit sw, output int g);
    bus.cfg_start = 8'(s);
    bus.cfg_stop  = 8'(t);
    bus.cfg_sweep = sw;
    bus.go        = 1'b1;
    @(negedge clk);
    g      = cyc;
    bus.go = 1'b0;
  endtask

  task automatic push_sweep(input int s, input int t, input int g);
    int f = s;
    int k = 1;
    while (f != t) begin
      f = (s < t) ? f + 1 : f - 1;
      exp_q.push_back('{1'b0, f, g + DW * N * k});
      k++;
    end
    exp_q.push_back('{1'b1, t, g + DW * N * k});
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic observe(input int n, output int rises, output int busy_low, output int high);
    logic prev;
    prev = bus.osc_out;
    rises = 0; busy_low = 0; high = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.osc_out && !prev) rises++;
      if (!bus.busy) busy_low++;
      if (bus.osc_out) high++;
      prev = bus.osc_out;
    end
  endtask

  task automatic pulse_halt();
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_osc"}, bus.osc_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_step"}, bus.step_tick, 0);
    check({tag, "_done"}, bus.sweep_done, 0);
  endtask

  initial begin
    int g, r, bl, hi;
    rst = 1'b1;
    bus.cfg_start = 8'd0; bus.cfg_stop = 8'd0; bus.cfg_sweep = 1'b0;
    bus.go = 1'b0; bus.halt = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outs("reset");
    check("reset_freq", bus.cur_freq, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Fixed 100 kHz
    start(100, 0, 1'b0, g);
    check("run_busy_rise", bus.busy, 1);
    check("run_freq", bus.cur_freq, 100);
    observe(N, r, bl, hi);
    check_rng("rises_100k", r, 99, 101);
    check("run_busy_held", bl, 0);

    // go while busy is ignored
    start(50, 0, 1'b0, g);
    check("go_busy_freq", bus.cur_freq, 100);
    observe(N, r, bl, hi);
    check_rng("rises_after_go", r, 99, 101);
    pulse_halt();
    check_idle_outs("halt_run");
    check("halt_run_freq", bus.cur_freq, 100);

    // Loopback-style count at 200 kHz
    start(200, 0, 1'b0, g);
    observe(N, r, bl, hi);
    check_rng("rises_200k", r, 199, 201);
    pulse_halt();

    // cur_freq 0: output frozen low, still busy
    start(0, 0, 1'b0, g);
    observe(N, r, bl, hi);
    check("zero_high_cycles", hi, 0);
    check("zero_busy_low", bl, 0);
    pulse_halt();
    repeat (3) @(negedge clk);

    // Ascending sweep 10 -> 12
    start(10, 12, 1'b1, g);
    push_sweep(10, 12, g);
    check("sweep_up_first", bus.cur_freq, 10);
    wait_drained("sweep_up_drained", 3 * DW * N + 20);
    check("sweep_up_osc", bus.osc_out, 0);
    check("sweep_up_busy", bus.busy, 0);
    check("sweep_up_hold", bus.cur_freq, 12);
    repeat (5) @(negedge clk);

    // Descending sweep 5 -> 3
    start(5, 3, 1'b1, g);
    push_sweep(5, 3, g);
    check("sweep_dn_first", bus.cur_freq, 5);
    wait_drained("sweep_dn_drained", 3 * DW * N + 20);
    check("sweep_dn_hold", bus.cur_freq, 3);
    repeat (5) @(negedge clk);

    // start == stop: one dwell then done
    start(7, 7, 1'b1, g);
    push_sweep(7, 7, g);
    wait_drained("sweep_eq_drained", DW * N + 20);
    check("sweep_eq_busy", bus.busy, 0);
    repeat (5) @(negedge clk);

    // halt 3 ms into sweep 10 -> 20
    start(10, 20, 1'b1, g);
    exp_q.push_back('{1'b0, 11, g + DW * N});
    while (cyc < g + 3 * N) @(negedge clk);
    pulse_halt();
    check_idle_outs("halt_sweep");
    check("halt_sweep_freq", bus.cur_freq, 11);
    check("halt_sweep_pending", exp_q.size(), 0);

    // go and halt together: halt wins
    bus.cfg_start = 8'd40; bus.cfg_sweep = 1'b0;
    bus.go = 1'b1; bus.halt = 1'b1;
    @(negedge clk);
    bus.go = 1'b0; bus.halt = 1'b0;
    repeat (3) @(negedge clk);
    check("go_halt_busy", bus.busy, 0);
    check("go_halt_freq", bus.cur_freq, 11);

    // rst mid-sweep
    start(10, 12, 1'b1, g);
    repeat (N) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outs("mid_rst");
    check("mid_rst_freq", bus.cur_freq, 0);
    repeat (3 * DW * N) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
